// File: rtl/char_line_fetch_pkg.sv
// Shared geometry constants and types for the text-mode line prefetcher.
package char_line_fetch_pkg;

    localparam int TXT_COLS = 128;
    localparam int TXT_ROWS = 75;
    localparam int CHAR_H   = 8;
    localparam int ACTIVE_H = 600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef logic [6:0] col_t;
    typedef logic [6:0] row_t;

    function automatic logic [14:0] row_offset(input row_t row);
        return {1'b0, row, 7'b000_0000};
    endfunction

endpackage

// File: rtl/char_line_fetch_line_buf.sv
// line_buf_2bank: 256x8 simple dual-port store, address = {bank, column}.
// Storage is not reset; only the registered read data is.
module line_buf_2bank (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:255];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/char_line_fetch.sv
// Double-buffered text row prefetcher from video RAM to the character PPU.
// Optional attribute fetch/store enabled by CHAR_LINE_FETCH_ATTR_EN.
module char_line_fetch
    import char_line_fetch_pkg::*;
#(
    parameter int          CORDW     = 12,
    parameter logic [14:0] TEXT_BASE = 15'h0000,
    parameter logic [14:0] ATTR_BASE = 15'h2800
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sy,
    output logic [14:0]             vid_address,
    input  logic [7:0]              vid_data,
    input  logic [6:0]              rd_col,
    output logic [7:0]              rd_char,
    output logic [7:0]              rd_attr,
    output logic                    busy,
    output logic                    overrun
);

`ifdef CHAR_LINE_FETCH_ATTR_EN
    localparam int   STEP_W  = 8;
    localparam logic ATTR_EN = 1'b1;
`else
    localparam int   STEP_W  = 7;
    localparam logic ATTR_EN = 1'b0;
`endif

    typedef logic [STEP_W-1:0] step_t;

    localparam step_t STEP_LAST = step_t'(TXT_COLS * (ATTR_EN ? 2 : 1) - 1);
    localparam logic signed [CORDW-1:0] SY_LIMIT = CORDW'(ACTIVE_H);

    // With attributes, even steps fetch chars and odd steps fetch attributes.
    function automatic col_t step_col(input step_t s);
`ifdef CHAR_LINE_FETCH_ATTR_EN
        return s[7:1];
`else
        return s[6:0];
`endif
    endfunction

    function automatic logic step_attr(input step_t s);
        return ATTR_EN & s[0];
    endfunction

    function automatic logic [14:0] fetch_addr(input row_t row, input step_t s);
        logic [14:0] base;
        base = step_attr(s) ? ATTR_BASE : TEXT_BASE;
        return base + row_offset(row) + {8'h00, step_col(s)};
    endfunction

    fetch_state_t state_r, state_next;
    step_t        step_r;
    row_t         row_r;
    logic         front_r;
    logic         wr_en_r;
    step_t        wr_step_r;

    logic in_range_s, swap_s, line_trig_s, trig_s;
    row_t sy_row_s, trig_row_s;

    assign in_range_s  = !sy[CORDW-1] && (sy < SY_LIMIT);
    assign sy_row_s    = row_t'(sy[9:3]);
    assign swap_s      = line && in_range_s && (sy[2:0] == 3'(0));
    assign line_trig_s = line && in_range_s && (sy[2:0] == 3'(CHAR_H - 1))
                         && (sy_row_s < row_t'(TXT_ROWS - 1));
    assign trig_s      = frame || line_trig_s;
    assign trig_row_s  = frame ? 7'd0 : (sy_row_s + 7'd1);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (trig_s) state_next = FETCH;
                else        state_next = IDLE;
            end
            FETCH: begin
                if (step_r == STEP_LAST) state_next = DRAIN;
                else                     state_next = FETCH;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // address generation, bank swap, error flag and write pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vid_address <= 15'h0000;
            step_r      <= '0;
            row_r       <= 7'd0;
            front_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_step_r   <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            wr_en_r   <= (state_r == FETCH);
            wr_step_r <= step_r;
            if (swap_s && !busy) begin
                front_r <= ~front_r;
            end
            if ((swap_s || trig_s) && busy) begin
                overrun <= 1'b1;
            end
            if (state_r == IDLE && trig_s) begin
                row_r       <= trig_row_s;
                step_r      <= '0;
                vid_address <= fetch_addr(trig_row_s, '0);
            end else if (state_r == FETCH && step_r != STEP_LAST) begin
                step_r      <= step_r + step_t'(1);
                vid_address <= fetch_addr(row_r, step_r + step_t'(1));
            end
        end
    end

    // Writes always land in the back half; swaps are blocked while busy.
    logic [7:0] waddr_s, raddr_s;
    assign waddr_s = {~front_r, step_col(wr_step_r)};
    assign raddr_s = {front_r, rd_col};

    line_buf_2bank u_char_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en_r && !step_attr(wr_step_r)),
        .waddr (waddr_s),
        .wdata (vid_data),
        .raddr (raddr_s),
        .rdata (rd_char)
    );

`ifdef CHAR_LINE_FETCH_ATTR_EN
    line_buf_2bank u_attr_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en_r && step_attr(wr_step_r)),
        .waddr (waddr_s),
        .wdata (vid_data),
        .raddr (raddr_s),
        .rdata (rd_attr)
    );
`else
    assign rd_attr = 8'h00;
`endif

endmodule

// File: tb/tb_char_line_fetch.sv
// Directed self-checking bench for char_line_fetch (default build and
// CHAR_LINE_FETCH_ATTR_EN build).
module tb_char_line_fetch;

`ifdef CHAR_LINE_FETCH_ATTR_EN
    localparam int LEN = 256;
`else
    localparam int LEN = 128;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame = 1'b0;
    logic               line = 1'b0;
    logic signed [11:0] sy = 12'sd0;
    logic [14:0]        vid_address;
    logic [7:0]         vid_data;
    logic [6:0]         rd_col = 7'd0;
    logic [7:0]         rd_char;
    logic [7:0]         rd_attr;
    logic               busy;
    logic               overrun;

    logic [7:0] vram [0:32767];
    int checks = 0;
    int errors = 0;

    char_line_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame       (frame),
        .line        (line),
        .sy          (sy),
        .vid_address (vid_address),
        .vid_data    (vid_data),
        .rd_col      (rd_col),
        .rd_char     (rd_char),
        .rd_attr     (rd_attr),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vid_data <= vram[vid_address];

    function automatic logic [14:0] exp_addr(input int r, input int k);
`ifdef CHAR_LINE_FETCH_ATTR_EN
        return 15'(((k % 2) != 0 ? 32'h2800 : 32'h0) + r * 128 + k / 2);
`else
        return 15'(r * 128 + k);
`endif
    endfunction

    function automatic logic [7:0] exp_attr(input int r, input int c);
`ifdef CHAR_LINE_FETCH_ATTR_EN
        return 8'(c * 3 + r + 1);
`else
        return 8'(r * 0 + c * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input int v);
        line = 1'b1;
        sy   = 12'(v);
        tick();
        line = 1'b0;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (vid_address !== 15'h0000 || busy !== 1'b0 || overrun !== 1'b0 ||
            rd_char !== 8'h00 || rd_attr !== 8'h00) begin
            errors++;
            $display("FAIL reset: addr=%h busy=%b ovr=%b char=%h attr=%h, expected 0000 0 0 00 00",
                     vid_address, busy, overrun, rd_char, rd_attr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_row0();
        int n, m;
        pulse_frame();
        n = 0;
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (vid_address !== exp_addr(0, k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL row0_addr k=%0d: addr=%h busy=%b, expected %h 1",
                         k, vid_address, busy, exp_addr(0, k));
            end
            n++;
            tick();
        end
        wait_idle(m);
        checks++;
        if (n + m !== LEN + 1) begin
            errors++;
            $display("FAIL row0_busy_len: got %0d, expected %0d", n + m, LEN + 1);
        end
        pulse_line(0);
        rd_col = 7'd5;
        tick();
        checks++;
        if (rd_char !== 8'h05 || rd_attr !== exp_attr(0, 5)) begin
            errors++;
            $display("FAIL row0_read: char=%h attr=%h, expected 05 %h", rd_char, rd_attr, exp_attr(0, 5));
        end
    endtask

    task automatic test_row74();
        int n;
        pulse_line(591);
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (vid_address !== exp_addr(74, k)) begin
                errors++;
                $display("FAIL row74_addr k=%0d: addr=%h, expected %h", k, vid_address, exp_addr(74, k));
            end
            tick();
        end
        wait_idle(n);
        pulse_line(592);
        rd_col = 7'd127;
        tick();
        checks++;
        if (rd_char !== 8'hC9 || rd_attr !== exp_attr(74, 127)) begin
            errors++;
            $display("FAIL row74_read: char=%h attr=%h, expected c9 %h", rd_char, rd_attr, exp_attr(74, 127));
        end
    endtask

    task automatic test_swap_boundary();
        int n;
        pulse_line(7);
        wait_idle(n);
        checks++;
        if (n !== LEN + 1) begin
            errors++;
            $display("FAIL row1_busy_len: got %0d, expected %0d", n, LEN + 1);
        end
        rd_col = 7'd3;
        pulse_line(8);
        checks++;
        if (rd_char !== 8'h4D) begin
            errors++;
            $display("FAIL swap_cycle_read: got %h, expected 4d", rd_char);
        end
        tick();
        checks++;
        if (rd_char !== 8'h04) begin
            errors++;
            $display("FAIL post_swap_read: got %h, expected 04", rd_char);
        end
    endtask

    task automatic test_overrun();
        int n;
        pulse_line(7);
        repeat (49) tick();
        pulse_line(7);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1 || vid_address !== exp_addr(1, 50)) begin
            errors++;
            $display("FAIL overrun_trigger: ovr=%b busy=%b addr=%h, expected 1 1 %h",
                     overrun, busy, vid_address, exp_addr(1, 50));
        end
        pulse_line(16);
        rd_col = 7'd100;
        tick();
        checks++;
        if (rd_char !== 8'd101) begin
            errors++;
            $display("FAIL swap_while_busy: got %h, expected %h", rd_char, 8'd101);
        end
        wait_idle(n);
        checks++;
        if (n !== LEN - 51) begin
            errors++;
            $display("FAIL overrun_busy_tail: got %0d, expected %0d", n, LEN - 51);
        end
        pulse_line(8);
        rd_col = 7'd10;
        tick();
        checks++;
        if (rd_char !== 8'd11) begin
            errors++;
            $display("FAIL overrun_data_col10: got %h, expected %h", rd_char, 8'd11);
        end
        rd_col = 7'd127;
        tick();
        checks++;
        if (rd_char !== 8'h80) begin
            errors++;
            $display("FAIL overrun_data_col127: got %h, expected 80", rd_char);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n, m;
        pulse_frame();
        n = 0;
        while (vid_address !== 15'h0040 && n < 500) begin
            n++;
            tick();
        end
        checks++;
        if (vid_address !== 15'h0040) begin
            errors++;
            $display("FAIL reach_0040: addr=%h, expected 0040", vid_address);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || vid_address !== 15'h0000 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b addr=%h ovr=%b, expected 0 0000 0", busy, vid_address, overrun);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b, expected 0", busy);
        end
        pulse_frame();
        n = 0;
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (vid_address !== exp_addr(0, k)) begin
                errors++;
                $display("FAIL refetch_addr k=%0d: addr=%h, expected %h", k, vid_address, exp_addr(0, k));
            end
            n++;
            tick();
        end
        wait_idle(m);
        checks++;
        if (n + m !== LEN + 1) begin
            errors++;
            $display("FAIL refetch_busy_len: got %0d, expected %0d", n + m, LEN + 1);
        end
    endtask

    task automatic test_ignored_lines();
        int vals [4] = '{3, 599, 607, -1};
        for (int i = 0; i < 4; i++) begin
            pulse_line(vals[i]);
            checks++;
            if (busy !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL ignored_line sy=%0d: busy=%b ovr=%b, expected 0 0", vals[i], busy, overrun);
            end
        end
    endtask

    task automatic test_frame_and_swap();
        int n;
        rd_col = 7'd7;
        frame  = 1'b1;
        pulse_line(0);
        frame  = 1'b0;
        checks++;
        if (busy !== 1'b1 || vid_address !== exp_addr(0, 0)) begin
            errors++;
            $display("FAIL coincide_fetch: busy=%b addr=%h, expected 1 %h", busy, vid_address, exp_addr(0, 0));
        end
        tick();
        checks++;
        if (rd_char !== 8'h07) begin
            errors++;
            $display("FAIL coincide_swap: got %h, expected 07", rd_char);
        end
        wait_idle(n);
        checks++;
        if (overrun !== 1'b0 || n !== LEN) begin
            errors++;
            $display("FAIL coincide_end: ovr=%b tail=%0d, expected 0 %0d", overrun, n, LEN);
        end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) vram[a] = 8'h00;
        for (int r = 0; r < 75; r++) begin
            for (int c = 0; c < 128; c++) begin
                vram[r * 128 + c]           = 8'(c + r);
                vram[32'h2800 + r * 128 + c] = 8'(c * 3 + r + 1);
            end
        end
        test_reset();
        test_row0();
        test_row74();
        test_swap_boundary();
        test_overrun();
        test_reset_mid_fetch();
        test_ignored_lines();
        test_frame_and_swap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
